// File: rtl/instr_operand_decoder_pkg.sv
// Shared RV32I opcode constants and operand-2 select encodings for the
// operand decoder and the downstream operand-2 extender.
package instr_operand_decoder_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // OP-IMM funct3 values that carry a shift amount instead of ImmI
    localparam logic [2:0] F3_SLLI = 3'b001;
    localparam logic [2:0] F3_SRXI = 3'b101;

    localparam logic [15:0] ILLEGAL_CNT_MAX = 16'hFFFF;

    typedef enum logic [4:0] {
        OP2_RS2    = 5'd0,
        OP2_IMMI   = 5'd1,
        OP2_IMMS   = 5'd2,
        OP2_SHAMTI = 5'd3,
        OP2_IMMU   = 5'd4
    } op2_sel_e;

endpackage

// File: rtl/instr_operand_decoder_op2_sel_decode.sv
// Combinational operand-2 select decode from opcode and funct3; flags any
// opcode outside the supported RV32I set as illegal.
module instr_operand_decoder_op2_sel_decode
    import instr_operand_decoder_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    output logic [4:0] op2_sel,
    output logic       illegal
);

    op2_sel_e sel;

    always_comb begin
        // NOTE: defaults first so every path assigns every output -- no latch.
        sel     = OP2_RS2;
        illegal = 1'b0;
        case (opcode)
            OPC_OP, OPC_BRANCH: sel = OP2_RS2;
            OPC_LOAD, OPC_JALR: sel = OP2_IMMI;
            OPC_OP_IMM: begin
                if (funct3 == F3_SLLI || funct3 == F3_SRXI) sel = OP2_SHAMTI;
                else                                        sel = OP2_IMMI;
            end
            OPC_STORE:          sel = OP2_IMMS;
            OPC_LUI, OPC_AUIPC: sel = OP2_IMMU;
            default:            illegal = 1'b1;
        endcase
    end

    assign op2_sel = sel;

endmodule

// File: rtl/instr_operand_decoder.sv
// One-entry valid/ready pipeline register holding a decoded RV32I operand-2
// view. Optional saturating illegal-opcode counter under ILLEGAL_CNT_EN.
module instr_operand_decoder
    import instr_operand_decoder_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] in_instr,
    output logic        in_ready,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  op2_sel,
    output logic [6:0]  imm7,
    output logic [4:0]  imm5,
    output logic [11:0] imm12,
    output logic [4:0]  shamt5,
    output logic [19:0] imm20,
    output logic        illegal
`ifdef ILLEGAL_CNT_EN
    ,
    output logic [15:0] illegal_cnt
`endif
);

    logic [4:0]  dec_sel;
    logic        dec_illegal;
    logic        accept;
    logic [31:0] instr_q;
    logic [4:0]  sel_q;
    logic        illegal_q;
    logic        valid_q;

    instr_operand_decoder_op2_sel_decode u_decode (
        .opcode  (in_instr[6:0]),
        .funct3  (in_instr[14:12]),
        .op2_sel (dec_sel),
        .illegal (dec_illegal)
    );

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    // NOTE: the held instruction is reset too, so field outputs read 0 in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: state registers use <= so all updates see pre-edge values.
            valid_q   <= 1'b0;
            instr_q   <= '0;
            sel_q     <= OP2_RS2;
            illegal_q <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q   <= 1'b1;
            instr_q   <= in_instr;
            sel_q     <= dec_sel;
            illegal_q <= dec_illegal;
        end else if (valid_q && out_ready) begin
            valid_q <= 1'b0;
        end
    end

`ifdef ILLEGAL_CNT_EN
    logic [15:0] cnt_q;

    // Counts accepted illegal words; flush does not clear history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (accept && dec_illegal && cnt_q != ILLEGAL_CNT_MAX) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign illegal_cnt = cnt_q;
`endif

    assign out_valid = valid_q;
    assign op2_sel   = sel_q;
    assign illegal   = illegal_q;
    assign imm7      = instr_q[31:25];
    assign imm5      = instr_q[11:7];
    assign imm12     = instr_q[31:20];
    assign shamt5    = instr_q[24:20];
    assign imm20     = instr_q[31:12];

endmodule

// File: tb/tb_instr_operand_decoder.sv
// Randomised and directed bench for instr_operand_decoder against a
// transaction-level reference model; covers ILLEGAL_CNT_EN when defined.
module tb_instr_operand_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  op2_sel;
    logic [6:0]  imm7;
    logic [4:0]  imm5;
    logic [11:0] imm12;
    logic [4:0]  shamt5;
    logic [19:0] imm20;
    logic        illegal;
`ifdef ILLEGAL_CNT_EN
    logic [15:0] illegal_cnt;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model: the held transaction and the illegal history
    logic        m_valid;
    logic [31:0] m_instr;
    logic [4:0]  m_sel;
    logic        m_ill;
    logic [15:0] m_cnt;

    always #5 clk = ~clk;

    instr_operand_decoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .op2_sel   (op2_sel),
        .imm7      (imm7),
        .imm5      (imm5),
        .imm12     (imm12),
        .shamt5    (shamt5),
        .imm20     (imm20),
        .illegal   (illegal)
`ifdef ILLEGAL_CNT_EN
        ,
        .illegal_cnt (illegal_cnt)
`endif
    );

    // Decode table as a lookup: returns {illegal, op2_sel}
    function automatic logic [5:0] ref_decode(input logic [31:0] w);
        int opc = int'(w[6:0]);
        int f3  = int'(w[14:12]);
        if (opc == 'h33 || opc == 'h63) return {1'b0, 5'd0};
        if (opc == 'h03 || opc == 'h67) return {1'b0, 5'd1};
        if (opc == 'h13) return (f3 == 1 || f3 == 5) ? {1'b0, 5'd3} : {1'b0, 5'd1};
        if (opc == 'h23) return {1'b0, 5'd2};
        if (opc == 'h37 || opc == 'h17) return {1'b0, 5'd4};
        return {1'b1, 5'd0};
    endfunction

    function automatic logic [55:0] obs_vec();
        return {out_valid, op2_sel, imm7, imm5, imm12, shamt5, imm20, illegal};
    endfunction

    function automatic logic [55:0] exp_vec();
        return {m_valid, m_sel, m_instr[31:25], m_instr[11:7], m_instr[31:20],
                m_instr[24:20], m_instr[31:12], m_ill};
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_instr = '0;
        m_sel   = '0;
        m_ill   = 1'b0;
        m_cnt   = '0;
    endtask

    task automatic set_inputs(input logic v, input logic [31:0] w,
                              input logic r, input logic f);
        in_valid  = v;
        in_instr  = w;
        out_ready = r;
        flush     = f;
    endtask

    // Advance the model over one edge using the current inputs, then the DUT
    task automatic tick();
        logic rdy, acc;
        rdy = !m_valid || out_ready;
        acc = in_valid && rdy && !flush;
        if (flush) begin
            m_valid = 1'b0;
        end else if (acc) begin
            m_valid        = 1'b1;
            m_instr        = in_instr;
            {m_ill, m_sel} = ref_decode(in_instr);
            if (m_ill && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] opcs [9];
        logic [31:0] w;
        opcs = '{7'h33, 7'h63, 7'h03, 7'h67, 7'h13, 7'h23, 7'h37, 7'h17, 7'h7F};
        w = $urandom;
        if ($urandom_range(0, 9) != 0) w[6:0] = opcs[$urandom_range(0, 8)];
        return w;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        set_inputs(1'b0, 32'h0, 1'b0, 1'b0);
        model_reset();
        #12;
        total++;
        if (obs_vec() !== 56'h0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0", obs_vec());
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
`ifdef ILLEGAL_CNT_EN
        total++;
        if (illegal_cnt !== 16'h0) begin
            bad++;
            $display("FAIL reset_cnt: got %h want 0", illegal_cnt);
        end
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_addi();
        set_inputs(1'b1, 32'h00500093, 1'b1, 1'b0);
        tick();
        set_inputs(1'b0, 32'h0, 1'b0, 1'b0);
        total++;
        if ({out_valid, op2_sel, imm12, illegal} !== {1'b1, 5'd1, 12'h005, 1'b0}) begin
            bad++;
            $display("FAIL addi: got v=%b sel=%0d imm12=%h ill=%b want v=1 sel=1 imm12=005 ill=0",
                     out_valid, op2_sel, imm12, illegal);
        end
        total++;
        if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL addi_model: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_back_to_back();
        // Held ADDI consumed while SRAI is accepted in the same cycle
        set_inputs(1'b1, 32'h40535293, 1'b1, 1'b0);
        tick();
        total++;
        if ({out_valid, op2_sel, shamt5, imm7} !== {1'b1, 5'd3, 5'd5, 7'h20}) begin
            bad++;
            $display("FAIL srai_b2b: got v=%b sel=%0d shamt=%0d imm7=%h want v=1 sel=3 shamt=5 imm7=20",
                     out_valid, op2_sel, shamt5, imm7);
        end
        total++;
        if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL srai_model: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_stall();
        logic [55:0] snap;
        set_inputs(1'b1, 32'h00112423, 1'b1, 1'b0);
        tick();
        snap = obs_vec();
        for (int i = 0; i < 3; i++) begin
            set_inputs(1'b1, 32'h00500093, 1'b0, 1'b0);
            #1;
            total++;
            if (in_ready !== 1'b0) begin
                bad++;
                $display("FAIL stall_in_ready[%0d]: got %b want 0", i, in_ready);
            end
            tick();
            total++;
            if (obs_vec() !== snap || op2_sel !== 5'd2 || imm5 !== 5'h08 || out_valid !== 1'b1) begin
                bad++;
                $display("FAIL stall_hold[%0d]: got %h want %h (sel=2 imm5=08)", i, obs_vec(), snap);
            end
        end
        set_inputs(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        total++;
        if (out_valid !== 1'b0 || obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL stall_consume: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_flush();
        set_inputs(1'b1, 32'h123452B7, 1'b1, 1'b1);
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_drop: got out_valid=%b want 0", out_valid);
        end
        set_inputs(1'b1, 32'h123452B7, 1'b0, 1'b0);
        tick();
        total++;
        if ({out_valid, op2_sel, imm20} !== {1'b1, 5'd4, 20'h12345}) begin
            bad++;
            $display("FAIL lui: got v=%b sel=%0d imm20=%h want v=1 sel=4 imm20=12345",
                     out_valid, op2_sel, imm20);
        end
        // Flush a held, stalled entry while a new word is offered
        set_inputs(1'b1, 32'h00500093, 1'b0, 1'b1);
        tick();
        total++;
        if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL flush_held: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        int errs = 0;
        for (int i = 0; i < 400; i++) begin
            set_inputs(1'($urandom_range(0, 3) != 0), rand_instr(),
                       1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
            #1;
            total++;
            if (in_ready !== (!m_valid || out_ready)) begin
                bad++;
                errs++;
                if (errs < 10) $display("FAIL rand_in_ready[%0d]: got %b want %b",
                                        i, in_ready, !m_valid || out_ready);
            end
            tick();
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                errs++;
                if (errs < 10) $display("FAIL rand_out[%0d]: got %h want %h", i, obs_vec(), exp_vec());
            end
`ifdef ILLEGAL_CNT_EN
            total++;
            if (illegal_cnt !== m_cnt) begin
                bad++;
                errs++;
                if (errs < 10) $display("FAIL rand_cnt[%0d]: got %h want %h", i, illegal_cnt, m_cnt);
            end
`endif
        end
    endtask

    task automatic test_reset_mid();
        set_inputs(1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
        tick();
        set_inputs(1'b0, 32'h0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        total++;
        if (obs_vec() !== 56'h0) begin
            bad++;
            $display("FAIL mid_reset: got %h want 0", obs_vec());
        end
`ifdef ILLEGAL_CNT_EN
        total++;
        if (illegal_cnt !== 16'h0) begin
            bad++;
            $display("FAIL mid_reset_cnt: got %h want 0", illegal_cnt);
        end
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_inputs(1'b1, 32'h00500093, 1'b1, 1'b0);
        tick();
        set_inputs(1'b0, 32'h0, 1'b1, 1'b0);
        total++;
        if ({out_valid, op2_sel, imm12} !== {1'b1, 5'd1, 12'h005} || obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL post_reset_accept: got %h want %h", obs_vec(), exp_vec());
        end
        tick();
    endtask

`ifdef ILLEGAL_CNT_EN
    task automatic test_illegal_cnt();
        for (int i = 0; i < 3; i++) begin
            set_inputs(1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
            tick();
        end
        set_inputs(1'b0, 32'h0, 1'b0, 1'b0);
        total++;
        if ({illegal, op2_sel, illegal_cnt} !== {1'b1, 5'd0, 16'd3}) begin
            bad++;
            $display("FAIL cnt3: got ill=%b sel=%0d cnt=%0d want ill=1 sel=0 cnt=3",
                     illegal, op2_sel, illegal_cnt);
        end
        // Flush must not clear the count
        set_inputs(1'b1, 32'hFFFFFFFF, 1'b1, 1'b1);
        tick();
        total++;
        if (illegal_cnt !== 16'd3) begin
            bad++;
            $display("FAIL cnt_flush: got %0d want 3", illegal_cnt);
        end
        for (int i = 0; i < 65540; i++) begin
            set_inputs(1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
            tick();
        end
        set_inputs(1'b0, 32'h0, 1'b1, 1'b0);
        total++;
        if (illegal_cnt !== 16'hFFFF || m_cnt !== 16'hFFFF) begin
            bad++;
            $display("FAIL cnt_sat: got %h want ffff", illegal_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_stall();
        test_flush();
        test_random();
        test_reset_mid();
`ifdef ILLEGAL_CNT_EN
        test_illegal_cnt();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
